sm83_adr_unit: RTL and testbench
================================

SM83_ADR_UNIT -- requirements
Module: sm83_adr_unit

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 16, address width in bits; even, >= 4.
REQ-002 SHALL have parameter BURST_WIDTH, default 8, burst length counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its falling edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port ain  in  ADR_WIDTH  address from internal bus.
REQ-006 SHALL have port aout  out  ADR_WIDTH  latched address al.
REQ-007 SHALL have port apin  out  ADR_WIDTH  combinational next address (pin drive).
REQ-008 SHALL have ports ctl_al_we, ctl_al_hi_ff, ctl_inc_dec, ctl_inc_cy, ctl_inc_oe, ctl_inc_step2  in  1 each: latch enable, force high half to all-ones, decrement, apply step, select incrementer output, step of 2 instead of 1.
REQ-009 SHALL have port inc_wrap  out  1  step crosses the address-space boundary.
REQ-010 SHALL have ports burst_start  in  1; burst_len  in  BURST_WIDTH; burst_busy  out  1; burst_done  out  1.

Function
REQ-011 inc SHALL equal al + step (ctl_inc_dec=0) or al - step (ctl_inc_dec=1) modulo 2^ADR_WIDTH when ctl_inc_cy=1, else al; step = 2 if ctl_inc_step2 else 1.
REQ-012 inc_wrap SHALL be 1 iff ctl_inc_cy=1 and the step carries out of (increment) or borrows from (decrement) bit ADR_WIDTH-1; combinational.
REQ-013 When ctl_al_we=0 and burst idle, apin SHALL equal al.
REQ-014 When ctl_al_we=1, apin high half SHALL be inc.hi if ctl_inc_oe, else all-ones if ctl_al_hi_ff, else ain.hi; low half SHALL be inc.lo if ctl_inc_oe, else ain.lo; ctl_inc_oe has priority over ctl_al_hi_ff.
REQ-015 al SHALL load apin on each falling edge where ctl_al_we=1 or burst state is BURST.
REQ-016 Burst FSM states: IDLE, BURST, DONE.
REQ-017 IDLE: burst_start=1 and ctl_al_we=0 SHALL capture burst_len into count and ctl_inc_dec/ctl_inc_step2 into burst direction/step; next state BURST if burst_len!=0, else DONE with al unchanged.
REQ-018 BURST: each cycle apin SHALL equal al +/- captured step (ignoring ctl_inc_* inputs), al loads apin, count decrements; after the edge where count was 1, next state DONE.
REQ-019 DONE: burst_done=1 for exactly one cycle, then IDLE; burst_busy=1 in BURST only.
REQ-020 ctl_al_we=1 in BURST or DONE SHALL take priority: al loads per REQ-014, FSM goes to IDLE, burst_done not asserted for the aborted burst.
REQ-021 burst_start while not IDLE SHALL be ignored; burst addresses wrap modulo 2^ADR_WIDTH without stopping.
REQ-022 inc_wrap in BURST SHALL reflect the captured direction/step.

Reset
REQ-023 reset low SHALL immediately set al=0, count=0, FSM=IDLE, burst_busy=0, burst_done=0; aout=0 and apin=0 while asserted.
REQ-024 Reset deassertion mid-burst SHALL resume from IDLE; no partial burst continues.

Configuration
REQ-025 Macro SM83_ADR_UNIT_BURST_EN SHALL compile in the burst FSM and counter.
REQ-026 Without SM83_ADR_UNIT_BURST_EN: burst_start and burst_len ignored, burst_busy=0 and burst_done=0 constantly, REQ-011..REQ-015 unchanged.

Verification
REQ-027 Load ain=0x12FE with ctl_al_we=1 -> aout=0x12FE; then ctl_inc_oe=1, ctl_inc_cy=1, ctl_inc_step2=1 -> aout=0x1300, inc_wrap=0.
REQ-028 al=0xFFFF, increment step 1 -> aout=0x0000, inc_wrap=1 during the cycle; al=0x0000, decrement step 2 -> 0xFFFE, inc_wrap=1.
REQ-029 ctl_al_we=1, ctl_al_hi_ff=1, ain=0x3C45 -> aout=0xFF45; same with ctl_inc_oe=1, al=0x0010, increment -> 0x0011.
REQ-030 al=0xC000, burst_start, burst_len=4, increment step 1 -> busy 4 cycles, aout 0xC001..0xC004, burst_done one cycle, then IDLE; burst_len=0 -> done next cycle, al=0xC000.
REQ-031 Burst len=8 from 0x0100, ctl_al_we=1 with ain=0x2000 at third burst cycle -> aout=0x2000, busy=0, burst_done never asserted.
REQ-032 reset low mid-burst -> aout=0, busy=0 immediately; build without SM83_ADR_UNIT_BURST_EN -> burst_start has no effect, busy/done stay 0.

Source files
------------

// File: rtl/sm83_adr_unit.sv
// SM83 address latch/incrementer with an optional auto-increment burst sequencer.
// Define SM83_ADR_UNIT_BURST_EN to build in the burst FSM and its counter.
module sm83_adr_unit #(
  parameter int ADR_WIDTH   = 16,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADR_WIDTH-1:0]   ain,
  output logic [ADR_WIDTH-1:0]   aout,
  output logic [ADR_WIDTH-1:0]   apin,
  input  logic                   ctl_al_we,
  input  logic                   ctl_al_hi_ff,
  input  logic                   ctl_inc_dec,
  input  logic                   ctl_inc_cy,
  input  logic                   ctl_inc_oe,
  input  logic                   ctl_inc_step2,
  output logic                   inc_wrap,
  input  logic                   burst_start,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   burst_busy,
  output logic                   burst_done
);

  localparam int HALF = ADR_WIDTH / 2;

  // MSB of the result is the carry (increment) or borrow (decrement) out of the address.
  function automatic logic [ADR_WIDTH:0] step_addr(
    input logic [ADR_WIDTH-1:0] a,
    input logic                 dec,
    input logic                 two
  );
    logic [ADR_WIDTH:0] ext_a;
    logic [ADR_WIDTH:0] ext_s;
    ext_a = {1'b0, a};
    ext_s = {{(ADR_WIDTH-1){1'b0}}, two, ~two};
    if (dec) begin
      step_addr = ext_a - ext_s;
    end else begin
      step_addr = ext_a + ext_s;
    end
  endfunction

  logic [ADR_WIDTH-1:0] al_q, al_d;
  logic [ADR_WIDTH:0]   ctl_sum_s;
  logic [ADR_WIDTH:0]   burst_sum_s;
  logic [ADR_WIDTH-1:0] inc_s;
  logic [ADR_WIDTH-1:0] apin_s;
  logic                 wrap_s;
  logic                 burst_drive_s;

`ifdef SM83_ADR_UNIT_BURST_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BURST = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam logic [BURST_WIDTH-1:0] CNT_ONE  = {{(BURST_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_WIDTH-1:0] CNT_ZERO = {BURST_WIDTH{1'b0}};

  state_e                 state_q, state_d;
  logic [BURST_WIDTH-1:0] count_q, count_d;
  logic                   dir_q, dir_d;
  logic                   step2_q, step2_d;

  // Burst sequencer state, counter and captured direction/step.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= CNT_ZERO;
      dir_q   <= 1'b0;
      step2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      step2_q <= step2_d;
    end
  end

  // Next burst state; an explicit latch write always aborts back to idle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    step2_d = step2_q;
    case (state_q)
      ST_IDLE: begin
        if (burst_start && !ctl_al_we) begin
          count_d = burst_len;
          dir_d   = ctl_inc_dec;
          step2_d = ctl_inc_step2;
          if (burst_len != CNT_ZERO) begin
            state_d = ST_BURST;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (ctl_al_we) begin
          state_d = ST_IDLE;
        end else begin
          count_d = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BURST;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign burst_drive_s = (state_q == ST_BURST);
  assign burst_sum_s   = step_addr(al_q, dir_q, step2_q);
  assign burst_busy    = (state_q == ST_BURST);
  assign burst_done    = (state_q == ST_DONE);
`else
  logic unused_s;

  assign unused_s      = &{1'b0, burst_start, burst_len};
  assign burst_drive_s = 1'b0;
  assign burst_sum_s   = {(ADR_WIDTH+1){1'b0}};
  assign burst_busy    = 1'b0;
  assign burst_done    = 1'b0;
`endif

  assign ctl_sum_s = step_addr(al_q, ctl_inc_dec, ctl_inc_step2);

  // Incrementer output and pin-address selection.
  always_comb begin
    apin_s = al_q;
    wrap_s = 1'b0;
    if (ctl_inc_cy) begin
      inc_s = ctl_sum_s[ADR_WIDTH-1:0];
    end else begin
      inc_s = al_q;
    end
    if (!reset) begin
      apin_s = {ADR_WIDTH{1'b0}};
      wrap_s = 1'b0;
    end else if (ctl_al_we) begin
      if (ctl_inc_oe) begin
        apin_s = inc_s;
      end else if (ctl_al_hi_ff) begin
        apin_s = {{(ADR_WIDTH-HALF){1'b1}}, ain[HALF-1:0]};
      end else begin
        apin_s = ain;
      end
      wrap_s = ctl_inc_cy & ctl_sum_s[ADR_WIDTH];
    end else if (burst_drive_s) begin
      apin_s = burst_sum_s[ADR_WIDTH-1:0];
      wrap_s = burst_sum_s[ADR_WIDTH];
    end else begin
      apin_s = al_q;
      wrap_s = ctl_inc_cy & ctl_sum_s[ADR_WIDTH];
    end
  end

  // Address latch loads the pin address on explicit writes and on every burst step.
  always_comb begin
    if (ctl_al_we || burst_drive_s) begin
      al_d = apin_s;
    end else begin
      al_d = al_q;
    end
  end

  // Address latch register.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      al_q <= {ADR_WIDTH{1'b0}};
    end else begin
      al_q <= al_d;
    end
  end

  assign aout     = al_q;
  assign apin     = apin_s;
  assign inc_wrap = wrap_s;

endmodule

// File: tb/tb_sm83_adr_unit.sv
// Self-checking bench for sm83_adr_unit: integer-arithmetic reference model with
// a per-cycle comparator, plus directed vectors with literal expectations.
module tb_sm83_adr_unit;

  localparam int W = 16;
  localparam int M = 65536;

  logic         clk   = 1'b1;
  logic         reset = 1'b0;
  logic [W-1:0] ain;
  logic [W-1:0] aout;
  logic [W-1:0] apin;
  logic         ctl_al_we, ctl_al_hi_ff, ctl_inc_dec, ctl_inc_cy, ctl_inc_oe, ctl_inc_step2;
  logic         inc_wrap;
  logic         burst_start;
  logic [7:0]   burst_len;
  logic         burst_busy, burst_done;

  int tests = 0;
  int fails = 0;

  // Reference model state: mode 0 idle, 1 burst, 2 done.
  int m_al   = 0;
  int m_mode = 0;
  int m_cnt  = 0;
  bit m_dir  = 1'b0;
  bit m_s2   = 1'b0;

  sm83_adr_unit #(.ADR_WIDTH(16), .BURST_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .ain(ain), .aout(aout), .apin(apin),
    .ctl_al_we(ctl_al_we), .ctl_al_hi_ff(ctl_al_hi_ff), .ctl_inc_dec(ctl_inc_dec),
    .ctl_inc_cy(ctl_inc_cy), .ctl_inc_oe(ctl_inc_oe), .ctl_inc_step2(ctl_inc_step2),
    .inc_wrap(inc_wrap), .burst_start(burst_start), .burst_len(burst_len),
    .burst_busy(burst_busy), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  function automatic int stepd(bit dec, bit two);
    int s;
    s = two ? 2 : 1;
    return dec ? -s : s;
  endfunction

  function automatic int modm(int x);
    return ((x % M) + M) % M;
  endfunction

  function automatic int exp_apin();
    int incv, hi, lo;
    if (!reset) return 0;
    if (!ctl_al_we && m_mode == 1) return modm(m_al + stepd(m_dir, m_s2));
    if (!ctl_al_we) return m_al;
    incv = ctl_inc_cy ? modm(m_al + stepd(ctl_inc_dec, ctl_inc_step2)) : m_al;
    hi = ctl_inc_oe ? incv / 256 : (ctl_al_hi_ff ? 255 : int'(ain) / 256);
    lo = ctl_inc_oe ? incv % 256 : int'(ain) % 256;
    return hi * 256 + lo;
  endfunction

  function automatic int exp_wrap();
    int raw;
    if (!ctl_al_we && m_mode == 1) raw = m_al + stepd(m_dir, m_s2);
    else if (ctl_inc_cy) raw = m_al + stepd(ctl_inc_dec, ctl_inc_step2);
    else return 0;
    return (raw < 0 || raw >= M) ? 1 : 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same falling edge as the design.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      m_al   <= 0;
      m_mode <= 0;
      m_cnt  <= 0;
    end else begin
      if (ctl_al_we || m_mode == 1) m_al <= exp_apin();
`ifdef SM83_ADR_UNIT_BURST_EN
      if (ctl_al_we) m_mode <= 0;
      else if (m_mode == 0) begin
        if (burst_start) begin
          m_cnt  <= int'(burst_len);
          m_dir  <= ctl_inc_dec;
          m_s2   <= ctl_inc_step2;
          m_mode <= (burst_len != 8'd0) ? 1 : 2;
        end
      end else if (m_mode == 1) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_mode <= 2;
      end else m_mode <= 0;
`endif
    end
  end

  // Per-cycle comparison on the rising edge, away from the falling update edge.
  initial begin
    forever begin
      @(posedge clk);
      chk("cyc_aout", int'(aout), m_al);
      chk("cyc_apin", int'(apin), exp_apin());
      chk("cyc_busy", int'(burst_busy), (m_mode == 1) ? 1 : 0);
      chk("cyc_done", int'(burst_done), (m_mode == 2) ? 1 : 0);
      if (reset) chk("cyc_wrap", int'(inc_wrap), exp_wrap());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ain = 16'h0000; ctl_al_we = 1'b0; ctl_al_hi_ff = 1'b0; ctl_inc_dec = 1'b0;
    ctl_inc_cy = 1'b0; ctl_inc_oe = 1'b0; ctl_inc_step2 = 1'b0;
    burst_start = 1'b0; burst_len = 8'd0;
  endtask

  initial begin
    bit saw_done;
    idle_inputs();
    tick(); tick();
    chk("reset_aout", int'(aout), 0);
    chk("reset_apin", int'(apin), 0);
    chk("reset_busy", int'(burst_busy), 0);
    reset = 1'b1;
    tick();

    ctl_al_we = 1'b1; ain = 16'h12FE; tick();
    chk("load_12fe", int'(aout), 16'h12FE);
    ctl_inc_oe = 1'b1; ctl_inc_cy = 1'b1; ctl_inc_step2 = 1'b1; #1;
    chk("inc2_apin", int'(apin), 16'h1300);
    chk("inc2_wrap", int'(inc_wrap), 0);
    tick();
    chk("inc2_aout", int'(aout), 16'h1300);

    ctl_inc_oe = 1'b0; ctl_inc_cy = 1'b0; ctl_inc_step2 = 1'b0; ain = 16'hFFFF; tick();
    ctl_inc_oe = 1'b1; ctl_inc_cy = 1'b1; #1;
    chk("incwrap_flag", int'(inc_wrap), 1);
    chk("incwrap_apin", int'(apin), 16'h0000);
    tick();
    chk("incwrap_aout", int'(aout), 16'h0000);
    ctl_inc_dec = 1'b1; ctl_inc_step2 = 1'b1; #1;
    chk("decwrap_flag", int'(inc_wrap), 1);
    tick();
    chk("decwrap_aout", int'(aout), 16'hFFFE);

    ctl_inc_oe = 1'b0; ctl_inc_cy = 1'b0; ctl_inc_dec = 1'b0; ctl_inc_step2 = 1'b0;
    ctl_al_hi_ff = 1'b1; ain = 16'h3C45; tick();
    chk("hiff_aout", int'(aout), 16'hFF45);
    ctl_al_hi_ff = 1'b0; ain = 16'h0010; tick();
    ctl_al_hi_ff = 1'b1; ctl_inc_oe = 1'b1; ctl_inc_cy = 1'b1; ain = 16'h3C45; tick();
    chk("oe_prio_aout", int'(aout), 16'h0011);
    ctl_al_we = 1'b0; ctl_al_hi_ff = 1'b0; #1;
    chk("hold_apin", int'(apin), 16'h0011);
    tick();
    chk("hold_aout", int'(aout), 16'h0011);

`ifdef SM83_ADR_UNIT_BURST_EN
    idle_inputs();
    ctl_al_we = 1'b1; ain = 16'hC000; tick();
    ctl_al_we = 1'b0; burst_start = 1'b1; burst_len = 8'd4; tick();
    chk("b4_busy0", int'(burst_busy), 1);
    chk("b4_aout0", int'(aout), 16'hC000);
    ctl_inc_dec = 1'b1; ctl_inc_step2 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      burst_start = (i <= 2);
      tick();
      chk("b4_aout", int'(aout), 16'hC000 + i);
      chk("b4_busy", int'(burst_busy), (i < 4) ? 1 : 0);
      chk("b4_done", int'(burst_done), (i == 4) ? 1 : 0);
    end
    tick();
    chk("b4_idle_done", int'(burst_done), 0);
    chk("b4_idle_aout", int'(aout), 16'hC004);

    idle_inputs();
    ctl_al_we = 1'b1; ain = 16'hC000; tick();
    ctl_al_we = 1'b0; burst_start = 1'b1; burst_len = 8'd0; tick();
    chk("b0_done", int'(burst_done), 1);
    chk("b0_aout", int'(aout), 16'hC000);
    burst_start = 1'b0; tick();
    chk("b0_after", int'(burst_done), 0);

    ctl_al_we = 1'b1; ain = 16'hFFFF; tick();
    ctl_al_we = 1'b0; burst_start = 1'b1; burst_len = 8'd2; tick();
    burst_start = 1'b0; #1;
    chk("bwrap_flag", int'(inc_wrap), 1);
    chk("bwrap_apin", int'(apin), 16'h0000);
    tick(); tick();
    chk("bwrap_aout", int'(aout), 16'h0001);
    chk("bwrap_done", int'(burst_done), 1);
    tick();

    ctl_al_we = 1'b1; ain = 16'h0100; tick();
    ctl_al_we = 1'b0; burst_start = 1'b1; burst_len = 8'd8; tick();
    burst_start = 1'b0; tick(); tick();
    chk("abort_pre", int'(aout), 16'h0102);
    ctl_al_we = 1'b1; ain = 16'h2000; tick();
    chk("abort_aout", int'(aout), 16'h2000);
    chk("abort_busy", int'(burst_busy), 0);
    ctl_al_we = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (burst_done) saw_done = 1'b1;
      tick();
    end
    chk("abort_no_done", int'(saw_done), 0);
`else
    idle_inputs();
    burst_start = 1'b1; burst_len = 8'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nob_busy", int'(burst_busy), 0);
      chk("nob_done", int'(burst_done), 0);
      chk("nob_aout", int'(aout), 16'h0011);
    end
`endif

    idle_inputs();
    ctl_al_we = 1'b1; ain = 16'h0100; tick();
    ctl_al_we = 1'b0; burst_start = 1'b1; burst_len = 8'd8; tick();
    burst_start = 1'b0; tick();
    reset = 1'b0; #1;
    chk("rst_mid_aout", int'(aout), 0);
    chk("rst_mid_apin", int'(apin), 0);
    chk("rst_mid_busy", int'(burst_busy), 0);
    chk("rst_mid_done", int'(burst_done), 0);
    tick();
    reset = 1'b1; tick(); tick();
    chk("rst_resume_busy", int'(burst_busy), 0);
    chk("rst_resume_aout", int'(aout), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
